// File: rtl/equeue_div.sv
// Collapsing, age-ordered issue queue for the integer divider with CDB operand wakeup.
// Optional EQUEUE_DIV_FLUSH_EN adds a synchronous active-high flush input.
module equeue_div #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
`ifdef EQUEUE_DIV_FLUSH_EN
  input  logic              flush,
`endif
  input  logic [TAG_W-1:0]  dispatch_rdtag,
  input  logic [TAG_W-1:0]  dispatch_rstag,
  input  logic [TAG_W-1:0]  dispatch_rttag,
  input  logic [DATA_W-1:0] dispatch_rsdata,
  input  logic [DATA_W-1:0] dispatch_rtdata,
  input  logic              dispatch_rsvalid,
  input  logic              dispatch_rtvalid,
  input  logic              dispatch_en,
  output logic              dispatch_ready,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [TAG_W-1:0]  issue_rdtag,
  output logic [DATA_W-1:0] issue_rsdata,
  output logic [DATA_W-1:0] issue_rtdata
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  rdtag;
    logic [TAG_W-1:0]  rstag;
    logic [TAG_W-1:0]  rttag;
    logic              rsv;
    logic              rtv;
    logic [DATA_W-1:0] rsdata;
    logic [DATA_W-1:0] rtdata;
  } entry_t;

  entry_t           ent_r [DEPTH];
  entry_t           ext_s [DEPTH+1];
  entry_t           nxt_s [DEPTH];
  entry_t           new_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic [CW-1:0]    wr_idx_s;
  logic [DEPTH-1:0] shift_s;
  logic [DEPTH-1:0] rs_hit_s;
  logic [DEPTH-1:0] rt_hit_s;
  logic             found_s;
  logic             fire_s;
  logic             accept_s;
  logic             flush_s;
  logic             new_rs_hit_s;
  logic             new_rt_hit_s;

`ifdef EQUEUE_DIV_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  assign dispatch_ready = (count_r < CW'(DEPTH));
  assign accept_s       = dispatch_en && dispatch_ready && !flush_s;
  assign fire_s         = issue_valid && issue_ready;

  // Oldest-first select: shift_s marks the selected slot and every younger one.
  always_comb begin
    found_s      = 1'b0;
    shift_s      = '0;
    issue_rdtag  = '0;
    issue_rsdata = '0;
    issue_rtdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found_s && ent_r[i].vld && ent_r[i].rsv && ent_r[i].rtv) begin
        found_s      = 1'b1;
        shift_s[i]   = 1'b1;
        issue_rdtag  = ent_r[i].rdtag;
        issue_rsdata = ent_r[i].rsdata;
        issue_rtdata = ent_r[i].rtdata;
      end else begin
        shift_s[i]   = found_s;
      end
    end
    issue_valid = found_s && !flush_s;
  end

  // Incoming op, already carrying any operand broadcast on the CDB this cycle.
  always_comb begin
    new_rs_hit_s = cdb_valid && !dispatch_rsvalid && (dispatch_rstag == cdb_tag);
    new_rt_hit_s = cdb_valid && !dispatch_rtvalid && (dispatch_rttag == cdb_tag);
    new_s.vld    = 1'b1;
    new_s.rdtag  = dispatch_rdtag;
    new_s.rstag  = dispatch_rstag;
    new_s.rttag  = dispatch_rttag;
    new_s.rsv    = dispatch_rsvalid | new_rs_hit_s;
    new_s.rtv    = dispatch_rtvalid | new_rt_hit_s;
    new_s.rsdata = new_rs_hit_s ? cdb_data : dispatch_rsdata;
    new_s.rtdata = new_rt_hit_s ? cdb_data : dispatch_rtdata;
  end

  // Next queue image: collapse on issue, then wakeup at post-shift index, then append.
  always_comb begin
    wr_idx_s = count_r - {{(CW-1){1'b0}}, fire_s};
    for (int i = 0; i < DEPTH; i++) begin
      ext_s[i] = ent_r[i];
    end
    ext_s[DEPTH] = '0;
    rs_hit_s     = '0;
    rt_hit_s     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      nxt_s[i]    = (fire_s && shift_s[i]) ? ext_s[i+1] : ext_s[i];
      rs_hit_s[i] = cdb_valid && nxt_s[i].vld && !nxt_s[i].rsv && (nxt_s[i].rstag == cdb_tag);
      rt_hit_s[i] = cdb_valid && nxt_s[i].vld && !nxt_s[i].rtv && (nxt_s[i].rttag == cdb_tag);
      nxt_s[i].rsdata = rs_hit_s[i] ? cdb_data : nxt_s[i].rsdata;
      nxt_s[i].rtdata = rt_hit_s[i] ? cdb_data : nxt_s[i].rtdata;
      nxt_s[i].rsv    = nxt_s[i].rsv | rs_hit_s[i];
      nxt_s[i].rtv    = nxt_s[i].rtv | rt_hit_s[i];
      nxt_s[i] = (accept_s && (wr_idx_s == CW'(i))) ? new_s : nxt_s[i];
    end
    if (flush_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        nxt_s[i] = '0;
      end
      count_nxt_s = '0;
    end else begin
      count_nxt_s = wr_idx_s + {{(CW-1){1'b0}}, accept_s};
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= '0;
      end
    end else begin
      count_r <= count_nxt_s;
      ent_r   <= nxt_s;
    end
  end

endmodule

// File: tb/tb_equeue_div.sv
// Directed self-checking bench for equeue_div (DEPTH=4, TAG_W=6, DATA_W=32).
// Flush scenario is built only when EQUEUE_DIV_FLUSH_EN is defined.
module tb_equeue_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [5:0]  dispatch_rdtag, dispatch_rstag, dispatch_rttag;
  logic [31:0] dispatch_rsdata, dispatch_rtdata;
  logic        dispatch_rsvalid, dispatch_rtvalid, dispatch_en;
  logic        dispatch_ready;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        issue_valid, issue_ready;
  logic [5:0]  issue_rdtag;
  logic [31:0] issue_rsdata, issue_rtdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  equeue_div #(.DEPTH(4), .TAG_W(6), .DATA_W(32)) dut (
    .clk(clk),
    .reset(reset),
`ifdef EQUEUE_DIV_FLUSH_EN
    .flush(flush),
`endif
    .dispatch_rdtag(dispatch_rdtag),
    .dispatch_rstag(dispatch_rstag),
    .dispatch_rttag(dispatch_rttag),
    .dispatch_rsdata(dispatch_rsdata),
    .dispatch_rtdata(dispatch_rtdata),
    .dispatch_rsvalid(dispatch_rsvalid),
    .dispatch_rtvalid(dispatch_rtvalid),
    .dispatch_en(dispatch_en),
    .dispatch_ready(dispatch_ready),
    .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag),
    .cdb_data(cdb_data),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_rdtag(issue_rdtag),
    .issue_rsdata(issue_rsdata),
    .issue_rtdata(issue_rtdata)
  );

  task automatic set_disp(input logic [5:0] rd, input logic [5:0] rs, input logic [5:0] rt,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic rsv, input logic rtv);
    dispatch_rdtag = rd; dispatch_rstag = rs; dispatch_rttag = rt;
    dispatch_rsdata = rsd; dispatch_rtdata = rtd;
    dispatch_rsvalid = rsv; dispatch_rtvalid = rtv;
    dispatch_en = 1'b1;
  endtask

  task automatic set_cdb(input logic [5:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
  endtask

  task automatic idle();
    dispatch_en = 1'b0; cdb_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL reset_dready: got %0b expected 1", dispatch_ready); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_ivalid: got %0b expected 0", issue_valid); end
    checks++; if ({issue_rdtag, issue_rsdata, issue_rtdata} !== 70'd0) begin errors++; $display("FAIL reset_idata: got %0h/%0h/%0h expected 0/0/0", issue_rdtag, issue_rsdata, issue_rtdata); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_basic();
    set_disp(6'd5, 6'd0, 6'd0, 32'd100, 32'd7, 1'b1, 1'b1);
    issue_ready = 1'b1;
    @(negedge clk); idle();
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1", issue_valid); end
    checks++; if (issue_rdtag !== 6'd5 || issue_rsdata !== 32'd100 || issue_rtdata !== 32'd7) begin errors++; $display("FAIL basic_data: got %0d/%0d/%0d expected 5/100/7", issue_rdtag, issue_rsdata, issue_rtdata); end
    @(negedge clk);
    checks++; if (issue_valid !== 1'b0 || dispatch_ready !== 1'b1) begin errors++; $display("FAIL basic_empty: got valid=%0b ready=%0b expected 0/1", issue_valid, dispatch_ready); end
  endtask

  task automatic test_wakeup();
    issue_ready = 1'b1;
    set_disp(6'd3, 6'd9, 6'd0, 32'd0, 32'd2, 1'b0, 1'b1);
    @(negedge clk);
    set_disp(6'd4, 6'd0, 6'd0, 32'd50, 32'd5, 1'b1, 1'b1);
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_wait: got %0b expected 0", issue_valid); end
    @(negedge clk); idle(); set_cdb(6'd9, 32'd42);
    checks++; if (issue_valid !== 1'b1 || issue_rdtag !== 6'd4) begin errors++; $display("FAIL wake_first: got valid=%0b rd=%0d expected 1/4", issue_valid, issue_rdtag); end
    @(negedge clk); idle();
    checks++; if (issue_valid !== 1'b1 || issue_rdtag !== 6'd3 || issue_rsdata !== 32'd42 || issue_rtdata !== 32'd2) begin errors++; $display("FAIL wake_second: got %0b rd=%0d rs=%0d rt=%0d expected 1/3/42/2", issue_valid, issue_rdtag, issue_rsdata, issue_rtdata); end
    @(negedge clk);
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_empty: got %0b expected 0", issue_valid); end
  endtask

  task automatic test_full();
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_disp(6'(10 + i), 6'd0, 6'd0, 32'(200 + i), 32'(1 + i), 1'b1, 1'b1);
      @(negedge clk);
    end
    checks++; if (dispatch_ready !== 1'b0) begin errors++; $display("FAIL full_dready: got %0b expected 0", dispatch_ready); end
    checks++; if (issue_valid !== 1'b1 || issue_rdtag !== 6'd10) begin errors++; $display("FAIL full_head: got valid=%0b rd=%0d expected 1/10", issue_valid, issue_rdtag); end
    set_disp(6'd14, 6'd0, 6'd0, 32'd1, 32'd1, 1'b1, 1'b1);
    issue_ready = 1'b1;
    @(negedge clk); idle();
    checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL full_reopen: got %0b expected 1", dispatch_ready); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (issue_valid !== 1'b1 || issue_rdtag !== 6'(10 + i) || issue_rsdata !== 32'(200 + i) || issue_rtdata !== 32'(1 + i)) begin errors++; $display("FAIL full_drain: got %0b rd=%0d rs=%0d rt=%0d expected 1/%0d/%0d/%0d", issue_valid, issue_rdtag, issue_rsdata, issue_rtdata, 10 + i, 200 + i, 1 + i); end
      @(negedge clk);
    end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL full_blocked_op: got valid=%0b rd=%0d expected 0", issue_valid, issue_rdtag); end
  endtask

  task automatic test_race();
    issue_ready = 1'b1;
    set_disp(6'd20, 6'd12, 6'd0, 32'd0, 32'd3, 1'b0, 1'b1);
    set_cdb(6'd12, 32'hDEAD);
    @(negedge clk); idle();
    checks++; if (issue_valid !== 1'b1 || issue_rdtag !== 6'd20 || issue_rsdata !== 32'hDEAD || issue_rtdata !== 32'd3) begin errors++; $display("FAIL race: got %0b rd=%0d rs=%0h rt=%0d expected 1/20/dead/3", issue_valid, issue_rdtag, issue_rsdata, issue_rtdata); end
    @(negedge clk);
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL race_empty: got %0b expected 0", issue_valid); end
  endtask

  task automatic test_oldest();
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_disp(6'(30 + i), 6'(40 + i), 6'd0, 32'd0, 32'(7 + i), 1'b0, 1'b1);
      @(negedge clk);
    end
    idle();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL old_none: got %0b expected 0", issue_valid); end
    set_cdb(6'd42, 32'h1111);
    @(negedge clk);
    checks++; if (issue_valid !== 1'b1 || issue_rdtag !== 6'd32 || issue_rsdata !== 32'h1111) begin errors++; $display("FAIL old_e2: got %0b rd=%0d rs=%0h expected 1/32/1111", issue_valid, issue_rdtag, issue_rsdata); end
    set_cdb(6'd40, 32'h2222);
    @(negedge clk); idle(); issue_ready = 1'b1;
    checks++; if (issue_valid !== 1'b1 || issue_rdtag !== 6'd30 || issue_rsdata !== 32'h2222 || issue_rtdata !== 32'd7) begin errors++; $display("FAIL old_e0: got %0b rd=%0d rs=%0h rt=%0d expected 1/30/2222/7", issue_valid, issue_rdtag, issue_rsdata, issue_rtdata); end
    @(negedge clk);
    checks++; if (issue_valid !== 1'b1 || issue_rdtag !== 6'd32 || issue_rtdata !== 32'd9) begin errors++; $display("FAIL old_order: got %0b rd=%0d rt=%0d expected 1/32/9", issue_valid, issue_rdtag, issue_rtdata); end
    @(negedge clk);
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL old_wait31: got %0b expected 0", issue_valid); end
    set_cdb(6'd41, 32'd5);
    @(negedge clk); idle();
    checks++; if (issue_valid !== 1'b1 || issue_rdtag !== 6'd31 || issue_rsdata !== 32'd5 || issue_rtdata !== 32'd8) begin errors++; $display("FAIL old_e1: got %0b rd=%0d rs=%0d rt=%0d expected 1/31/5/8", issue_valid, issue_rdtag, issue_rsdata, issue_rtdata); end
    @(negedge clk);
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL old_empty: got %0b expected 0", issue_valid); end
  endtask

  task automatic test_back_to_back();
    issue_ready = 1'b1;
    set_disp(6'd50, 6'd0, 6'd0, 32'd8, 32'd2, 1'b1, 1'b1);
    @(negedge clk);
    set_disp(6'd51, 6'd0, 6'd0, 32'd9, 32'd3, 1'b1, 1'b1);
    checks++; if (issue_valid !== 1'b1 || issue_rdtag !== 6'd50) begin errors++; $display("FAIL b2b_first: got %0b rd=%0d expected 1/50", issue_valid, issue_rdtag); end
    @(negedge clk); idle();
    checks++; if (issue_valid !== 1'b1 || issue_rdtag !== 6'd51 || issue_rsdata !== 32'd9) begin errors++; $display("FAIL b2b_second: got %0b rd=%0d rs=%0d expected 1/51/9", issue_valid, issue_rdtag, issue_rsdata); end
    @(negedge clk);
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %0b expected 0", issue_valid); end
  endtask

  task automatic test_midreset();
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_disp(6'(60 + i), 6'd0, 6'd0, 32'(i), 32'(i), 1'b1, 1'b1);
      @(negedge clk);
    end
    idle();
    checks++; if (issue_valid !== 1'b1 || issue_rdtag !== 6'd60) begin errors++; $display("FAIL mrst_pre: got %0b rd=%0d expected 1/60", issue_valid, issue_rdtag); end
    #2 reset = 1'b0;
    #1;
    checks++; if (dispatch_ready !== 1'b1 || issue_valid !== 1'b0) begin errors++; $display("FAIL mrst_now: got ready=%0b valid=%0b expected 1/0", dispatch_ready, issue_valid); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    checks++; if (issue_valid !== 1'b0 || dispatch_ready !== 1'b1) begin errors++; $display("FAIL mrst_after: got valid=%0b ready=%0b expected 0/1", issue_valid, dispatch_ready); end
  endtask

`ifdef EQUEUE_DIV_FLUSH_EN
  task automatic test_flush();
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_disp(6'(1 + i), 6'd0, 6'd0, 32'd1, 32'd1, 1'b1, 1'b1);
      @(negedge clk);
    end
    set_disp(6'd7, 6'd0, 6'd0, 32'd1, 32'd1, 1'b1, 1'b1);
    flush = 1'b1;
    #1;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_force: got %0b expected 0", issue_valid); end
    @(negedge clk); flush = 1'b0; idle();
    checks++; if (issue_valid !== 1'b0 || dispatch_ready !== 1'b1) begin errors++; $display("FAIL flush_clear: got valid=%0b ready=%0b expected 0/1", issue_valid, dispatch_ready); end
  endtask
`endif

  initial begin
    reset = 1'b0; flush = 1'b0; issue_ready = 1'b0;
    dispatch_rdtag = '0; dispatch_rstag = '0; dispatch_rttag = '0;
    dispatch_rsdata = '0; dispatch_rtdata = '0;
    dispatch_rsvalid = 1'b0; dispatch_rtvalid = 1'b0; dispatch_en = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    test_reset();
    test_basic();
    test_wakeup();
    test_full();
    test_race();
    test_oldest();
    test_back_to_back();
    test_midreset();
`ifdef EQUEUE_DIV_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
